banco_registros: RTL and testbench

//  Four-entry register bank that sits directly upstream of the 4:1 output mux.
//  It holds the operands on R_0..R_3 and generates the mux select selecM.

---
 rtl/banco_registros_if.sv | 32 +++
 rtl/banco_registros.sv | 113 +++++++++++
 tb/tb_banco_registros.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/banco_registros_if.sv
// banco_registros_if: bus bundle for the four-entry register bank.
// Optional macro: CLR_ALL_EN (adds the clr_all synchronous clear line).
//   master : drives the write port and the select controls, reads R_0..R_3/selecM/cambio
//   slave  : the register bank itself
interface banco_registros_if #(parameter int N = 16);
    logic         we;
    logic [1:0]   dir_w;
    logic [N-1:0] dato_w;
    logic         modo;
    logic [1:0]   sel_in;
`ifdef CLR_ALL_EN
    logic         clr_all;
`endif
    logic [N-1:0] R_0;
    logic [N-1:0] R_1;
    logic [N-1:0] R_2;
    logic [N-1:0] R_3;
    logic [1:0]   selecM;
    logic         cambio;

`ifdef CLR_ALL_EN
    modport master (output we, dir_w, dato_w, modo, sel_in, clr_all,
                    input  R_0, R_1, R_2, R_3, selecM, cambio);
    modport slave  (input  we, dir_w, dato_w, modo, sel_in, clr_all,
                    output R_0, R_1, R_2, R_3, selecM, cambio);
`else
    modport master (output we, dir_w, dato_w, modo, sel_in,
                    input  R_0, R_1, R_2, R_3, selecM, cambio);
    modport slave  (input  we, dir_w, dato_w, modo, sel_in,
                    output R_0, R_1, R_2, R_3, selecM, cambio);
`endif
endinterface

// File: rtl/banco_registros.sv
// banco_registros: four-entry register bank feeding a 4:1 output mux, plus the
// mux select generator (manual select or auto-scan sequencer).
// Optional macro: CLR_ALL_EN (clr_all clears R_0..R_3, priority over writes).
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous, active-high, clears all state
//   bus    : banco_registros_if.slave (write port, modo/sel_in, R_0..R_3, selecM, cambio)
// Parameters: N data width, DIV cycles per scan slot (1..65535).
//
// state  | meaning
// MANUAL | selecM follows sel_in, slot counter held at 0
// SCAN   | selecM steps 00,10,01,11 holding each value DIV cycles
module banco_registros #(
    parameter int N   = 16,
    parameter int DIV = 4
) (
    input  logic             clk,
    input  logic             reset,
    banco_registros_if.slave bus
);
    typedef enum logic {MANUAL, SCAN} estado_t;

    localparam int            CW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    estado_t      estado, estado_sig;
    logic [CW-1:0] cnt, cnt_sig;
    logic [1:0]   slot, slot_sig;
    logic [1:0]   sel_sig;
    logic [1:0]   selecm_q;
    logic         cambio_q;
    logic [N-1:0] regs [4];
    logic         clr;

`ifdef CLR_ALL_EN
    assign clr = bus.clr_all;
`else
    assign clr = 1'b0;
`endif

    // Slot index to mux select encoding: R_1 is 10, R_2 is 01.
    function automatic logic [1:0] slot_a_sel(input logic [1:0] s);
        case (s)
            2'd0:    slot_a_sel = 2'b00;
            2'd1:    slot_a_sel = 2'b10;
            2'd2:    slot_a_sel = 2'b01;
            default: slot_a_sel = 2'b11;
        endcase
    endfunction

    always_comb begin
        estado_sig = estado;
        cnt_sig    = '0;
        slot_sig   = slot;
        sel_sig    = bus.sel_in;
        case (estado)
            MANUAL: begin
                if (bus.modo) begin
                    estado_sig = SCAN;
                    slot_sig   = 2'd0;
                    sel_sig    = 2'b00;
                end
            end
            SCAN: begin
                if (!bus.modo) begin
                    estado_sig = MANUAL;
                end else begin
                    if (cnt == CNT_MAX) begin
                        slot_sig = slot + 2'd1;
                    end else begin
                        cnt_sig = cnt + 1'b1;
                    end
                    sel_sig = slot_a_sel(slot_sig);
                end
            end
            default: estado_sig = MANUAL;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado   <= MANUAL;
            cnt      <= '0;
            slot     <= 2'd0;
            selecm_q <= 2'b00;
            cambio_q <= 1'b0;
        end else begin
            estado   <= estado_sig;
            cnt      <= cnt_sig;
            slot     <= slot_sig;
            selecm_q <= sel_sig;
            cambio_q <= (sel_sig != selecm_q);
        end
    end

    // Write path is independent of the sequencer; both may act on one edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else if (bus.we) begin
            regs[bus.dir_w] <= bus.dato_w;
        end
    end

    assign bus.R_0    = regs[0];
    assign bus.R_1    = regs[1];
    assign bus.R_2    = regs[2];
    assign bus.R_3    = regs[3];
    assign bus.selecM = selecm_q;
    assign bus.cambio = cambio_q;
endmodule

// File: tb/tb_banco_registros.sv
module tb_banco_registros;
    localparam int N   = 16;
    localparam int DIV = 4;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    banco_registros_if #(.N(N)) bus ();
    banco_registros #(.N(N), .DIV(DIV)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // Reference model
    logic [N-1:0] m_reg [4];
    logic [1:0]   m_sel;
    logic         m_cambio;
    bit           m_scan;
    int           m_age;
    logic [1:0]   seq [4];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_reg[i] = '0;
        m_sel = 2'b00; m_cambio = 1'b0; m_scan = 0; m_age = 0;
    endtask

    task automatic model_edge();
        logic [1:0] nsel;
        bit clr_now;
        clr_now = 0;
`ifdef CLR_ALL_EN
        clr_now = bus.clr_all;
`endif
        if (clr_now) for (int i = 0; i < 4; i++) m_reg[i] = '0;
        else if (bus.we) m_reg[bus.dir_w] = bus.dato_w;
        if (!bus.modo) begin
            m_scan = 0;
            nsel = bus.sel_in;
        end else if (!m_scan) begin
            m_scan = 1;
            m_age = 0;
            nsel = seq[0];
        end else begin
            m_age++;
            nsel = seq[(m_age / DIV) % 4];
        end
        m_cambio = (nsel != m_sel);
        m_sel = nsel;
    endtask

    task automatic check_all();
        chk("r0", 32'(bus.R_0), 32'(m_reg[0]));
        chk("r1", 32'(bus.R_1), 32'(m_reg[1]));
        chk("r2", 32'(bus.R_2), 32'(m_reg[2]));
        chk("r3", 32'(bus.R_3), 32'(m_reg[3]));
        chk("selecM", 32'(bus.selecM), 32'(m_sel));
        chk("cambio", 32'(bus.cambio), 32'(m_cambio));
    endtask

    // One clock: model follows the edge, outputs checked on the falling edge.
    task automatic step();
        @(posedge clk);
        if (reset) model_reset(); else model_edge();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        int pulses;
        int guard;
        seq[0] = 2'b00; seq[1] = 2'b10; seq[2] = 2'b01; seq[3] = 2'b11;
        reset = 1'b1;
        bus.we = 1'b0; bus.dir_w = 2'd0; bus.dato_w = '0;
        bus.modo = 1'b0; bus.sel_in = 2'b00;
`ifdef CLR_ALL_EN
        bus.clr_all = 1'b0;
`endif
        model_reset();
        @(negedge clk);
        for (int i = 0; i < 3; i++) step();
        reset = 1'b0;
        step();
        chk("t1_sel", 32'(bus.selecM), 32'h0);
        chk("t1_cambio", 32'(bus.cambio), 32'h0);

        // Write path
        bus.we = 1'b1; bus.dir_w = 2'd2; bus.dato_w = 16'hBEEF;
        step();
        bus.we = 1'b0;
        chk("t2_r2", 32'(bus.R_2), 32'hBEEF);
        chk("t2_r0", 32'(bus.R_0), 32'h0);
        step();

        // Manual select
        bus.sel_in = 2'b11;
        step();
        chk("t3_sel", 32'(bus.selecM), 32'h3);
        chk("t3_cambio_hi", 32'(bus.cambio), 32'h1);
        step();
        chk("t3_cambio_lo", 32'(bus.cambio), 32'h0);

        // Auto scan, with writes running alongside
        bus.modo = 1'b1;
        pulses = 0;
        for (int k = 0; k < 17; k++) begin
            bus.we = 1'b1; bus.dir_w = 2'(k); bus.dato_w = 16'(k * 16'h1111 + 1);
            step();
            chk("t4_seq", 32'(bus.selecM), 32'(seq[(k / DIV) % 4]));
            if (bus.cambio) pulses++;
        end
        bus.we = 1'b0;
        chk("t4_pulses", 32'(pulses), 32'd5);

        // Reset mid-scan while selecM = 01
        guard = 0;
        while (bus.selecM != 2'b01 && guard < 40) begin
            step();
            guard++;
        end
        chk("t5_reach01", 32'(bus.selecM), 32'h1);
        reset = 1'b1;
        #1;
        chk("t5_sel_async", 32'(bus.selecM), 32'h0);
        chk("t5_r0_async", 32'(bus.R_0), 32'h0);
        chk("t5_r3_async", 32'(bus.R_3), 32'h0);
        model_reset();
        step();
        reset = 1'b0;
        step();
        chk("t5_restart", 32'(bus.selecM), 32'h0);
        for (int k = 0; k < 6; k++) step();

`ifdef CLR_ALL_EN
        bus.we = 1'b1; bus.dir_w = 2'd1; bus.dato_w = 16'h5555;
        step();
        bus.clr_all = 1'b1; bus.dir_w = 2'd0; bus.dato_w = 16'h1234;
        step();
        chk("t6_clr_r0", 32'(bus.R_0), 32'h0);
        chk("t6_clr_r1", 32'(bus.R_1), 32'h0);
        bus.clr_all = 1'b0; bus.we = 1'b0;
        step();
`endif

        // Randomized traffic
        for (int k = 0; k < 500; k++) begin
            bus.we = 1'($urandom);
            bus.dir_w = 2'($urandom);
            bus.dato_w = 16'($urandom);
            bus.sel_in = 2'($urandom);
            if ($urandom_range(0, 15) == 0) bus.modo = ~bus.modo;
            reset = ($urandom_range(0, 199) == 0);
`ifdef CLR_ALL_EN
            bus.clr_all = ($urandom_range(0, 7) == 0);
`endif
            step();
        end
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
